// File: rtl/pea_cmd_scheduler.sv
// pea_cmd_scheduler: PEA instruction sequencer.
// Counts pending command tokens, asks the get-command FSM to fetch and split one,
// then dispatches it to STP/EVP/EVB/RST with a start/done handshake.
// Only one command is in flight at a time.
module pea_cmd_scheduler #(
  parameter  int buffer_size = 1024,
  localparam int CW          = $clog2(buffer_size) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cmd_wr,
  output logic          start_get_cmd,
  input  logic          done_get_cmd,
  input  logic [7:0]    instr,
  input  logic [2:0]    arg1,
  input  logic [4:0]    arg2,
  output logic          start_stp,
  output logic          start_evp,
  output logic          start_evb,
  output logic          start_rst,
  input  logic          done_stp,
  input  logic          done_evp,
  input  logic          done_evb,
  input  logic          done_rst,
  output logic [2:0]    exec_arg1,
  output logic [4:0]    exec_arg2,
  output logic [CW-1:0] pending,
  output logic          busy,
  output logic          err_instr,
  output logic [15:0]   instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_CMD, DECODE, WAIT_EXEC} state_t;

  state_t      state, state_nxt;
  logic [7:0]  instr_q;
  logic [2:0]  arg1_q;
  logic [4:0]  arg2_q;
  logic [3:0]  start_vec;
  logic [3:0]  done_vec;
  logic        op_valid;
  logic        unit_done;
  logic        full;
  logic        inc, dec;

  // Units indexed by the low opcode bits: 0 STP, 1 EVP, 2 EVB, 3 RST.
  assign done_vec  = {done_rst, done_evb, done_evp, done_stp};
  assign op_valid  = (instr_q[7:2] == 6'd0);
  // instr_q is held through WAIT_EXEC, so it still names the selected unit.
  assign unit_done = done_vec[instr_q[1:0]];

  assign start_stp = start_vec[0];
  assign start_evp = start_vec[1];
  assign start_evb = start_vec[2];
  assign start_rst = start_vec[3];
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and single-cycle start pulses.
  always_comb begin
    state_nxt     = state;
    start_get_cmd = 1'b0;
    start_vec     = 4'd0;
    case (state)
      IDLE:      if (enable && (pending != '0)) state_nxt = FETCH;
      FETCH: begin
        start_get_cmd = 1'b1;
        state_nxt     = WAIT_CMD;
      end
      WAIT_CMD:  if (done_get_cmd) state_nxt = DECODE;
      DECODE: begin
        if (op_valid) begin
          start_vec[instr_q[1:0]] = 1'b1;
          state_nxt               = WAIT_EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_EXEC: if (unit_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Capture the split command once the get-command FSM reports it done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      arg1_q  <= '0;
      arg2_q  <= '0;
    end else if ((state == WAIT_CMD) && done_get_cmd) begin
      instr_q <= instr;
      arg1_q  <= arg1;
      arg2_q  <= arg2;
    end
  end

  // Execution arguments, error flag and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_arg1   <= '0;
      exec_arg2   <= '0;
      err_instr   <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == DECODE) begin
        if (op_valid) begin
          exec_arg1 <= arg1_q;
          exec_arg2 <= arg2_q;
        end else begin
          err_instr <= 1'b1;
        end
      end
      if ((state == WAIT_EXEC) && unit_done) instr_count <= instr_count + 16'd1;
    end
  end

  // Token count: a write while full is dropped unless a fetch frees a slot in the same cycle.
  assign full = (pending == CW'(buffer_size));
  assign dec  = (state == FETCH);
  assign inc  = cmd_wr && (!full || dec);

  // Pending token counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pending <= '0;
    else if (inc && !dec) pending <= pending + 1'b1;
    else if (dec && !inc) pending <= pending - 1'b1;
  end

endmodule

// File: tb/tb_pea_cmd_scheduler.sv
// Bench for pea_cmd_scheduler: a get-command responder and an execution-unit
// responder model the neighbours; dispatches are checked against a scoreboard.
module tb_pea_cmd_scheduler;

  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          cmd_wr = 1'b0;
  logic          start_get_cmd;
  logic          done_get_cmd;
  logic [7:0]    instr;
  logic [2:0]    arg1;
  logic [4:0]    arg2;
  logic          start_stp, start_evp, start_evb, start_rst;
  logic [3:0]    done_auto = 4'd0;
  logic [3:0]    done_man  = 4'd0;
  logic [2:0]    exec_arg1;
  logic [4:0]    exec_arg2;
  logic [CW-1:0] pending;
  logic          busy;
  logic          err_instr;
  logic [15:0]   instr_count;

  pea_cmd_scheduler #(.buffer_size(1024)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_wr(cmd_wr),
    .start_get_cmd(start_get_cmd), .done_get_cmd(done_get_cmd),
    .instr(instr), .arg1(arg1), .arg2(arg2),
    .start_stp(start_stp), .start_evp(start_evp), .start_evb(start_evb), .start_rst(start_rst),
    .done_stp(done_auto[0] | done_man[0]), .done_evp(done_auto[1] | done_man[1]),
    .done_evb(done_auto[2] | done_man[2]), .done_rst(done_auto[3] | done_man[3]),
    .exec_arg1(exec_arg1), .exec_arg2(exec_arg2), .pending(pending),
    .busy(busy), .err_instr(err_instr), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [2:0] a1;
    logic [4:0] a2;
    int         gd;    // get-command extra wait cycles
    int         xd;    // execution unit extra wait cycles
    int         unit;  // expected unit, 4 = invalid opcode
  } vec_t;

  typedef struct {
    int         unit;
    logic [2:0] a1;
    logic [4:0] a2;
    int         lat;
    int         xd;
  } exp_t;

  vec_t cmd_q[$];
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_get = 0;
  bit   auto_exec = 1'b1;
  bit   exec_active = 1'b0;
  int   exp_cnt = 0;
  int   exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input vec_t v);
    exp_t e;
    cmd_q.push_back(v);
    if (v.unit < 4) begin
      e.unit = v.unit; e.a1 = v.a1; e.a2 = v.a2; e.lat = 2 + v.gd; e.xd = v.xd;
      exp_q.push_back(e);
      exp_cnt++;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic wr_tokens(input int n);
    @(posedge clk); #1 cmd_wr = 1'b1;
    repeat (n) @(posedge clk);
    #1 cmd_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || pending != 0 || cmd_q.size() != 0 || exp_q.size() != 0 || exec_active)
               && n < budget);
    check({name, "_timeout"}, (n >= budget), 0);
    repeat (2) @(negedge clk);
  endtask

  // Get-command FSM model: answers each fetch with the next queued command.
  initial begin
    vec_t c;
    done_get_cmd = 1'b0; instr = 8'h00; arg1 = 3'd0; arg2 = 5'd0;
    forever begin
      @(negedge clk);
      if (start_get_cmd) begin
        t_get = cyc;
        if (cmd_q.size() == 0) begin
          check("get_cmd_unexpected", 1, 0);
        end else begin
          c = cmd_q.pop_front();
          repeat (1 + c.gd) @(negedge clk);
          instr = c.instr; arg1 = c.a1; arg2 = c.a2; done_get_cmd = 1'b1;
          @(negedge clk);
          done_get_cmd = 1'b0; instr = 8'hEE; arg1 = 3'd0; arg2 = 5'd0;
        end
      end
    end
  end

  // Execution unit model and dispatch scoreboard.
  initial begin
    exp_t       e;
    int         nst;
    logic [1:0] u, w;
    forever begin
      @(negedge clk);
      nst = int'(start_stp) + int'(start_evp) + int'(start_evb) + int'(start_rst);
      if (nst > 1) begin
        check("start_overlap", nst, 1);
      end else if (nst == 1) begin
        u = start_evp ? 2'd1 : start_evb ? 2'd2 : start_rst ? 2'd3 : 2'd0;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          exec_active = 1'b1;
          check("dispatch_unit", u, e.unit);
          check("dispatch_latency", cyc - t_get, e.lat);
          @(negedge clk);
          check("exec_arg1", exec_arg1, e.a1);
          check("exec_arg2", exec_arg2, e.a2);
          if (auto_exec) begin
            w = u + 2'd1;
            done_auto[w] = 1'b1;
            @(negedge clk);
            done_auto = 4'd0;
            check("busy_after_wrong_done", busy, 1);
            repeat (e.xd) @(negedge clk);
            done_auto[u] = 1'b1;
            @(negedge clk);
            done_auto = 4'd0;
          end
          exec_active = 1'b0;
        end
      end
    end
  end

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{8'h00, 3'd1, 5'd2,  0, 0, 0};
    vecs[1] = '{8'h02, 3'd7, 5'd31, 2, 1, 2};
    vecs[2] = '{8'h03, 3'd0, 5'd0,  1, 3, 3};
    vecs[3] = '{8'h7A, 3'd4, 5'd5,  0, 0, 4};
    vecs[4] = '{8'h01, 3'd6, 5'd10, 3, 0, 1};
    vecs[5] = '{8'hFF, 3'd1, 5'd1,  0, 0, 4};

    // 1. reset state and quiet idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_count", instr_count, 0);
    check("rst_err", err_instr, 0);
    check("rst_args", {exec_arg1, exec_arg2}, 0);
    check("rst_starts", {start_get_cmd, start_stp, start_evp, start_evb, start_rst}, 0);
    rst = 1'b0; enable = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(start_get_cmd | start_stp | start_evp | start_evb | start_rst | busy);
    end
    check("idle_activity", n, 0);
    check("idle_pending", pending, 0);

    // 2. single EVP command
    push_cmd('{8'h01, 3'd3, 5'd17, 0, 0, 1});
    wr_tokens(1);
    wait_idle("single", 200);
    check("single_count", instr_count, 1);
    check("single_pending", pending, 0);
    check("single_arg1", exec_arg1, 3);
    check("single_arg2", exec_arg2, 17);

    // 3/4. table rows one at a time, then back-to-back
    for (int i = 0; i < 6; i++) begin
      push_cmd(vecs[i]);
      wr_tokens(1);
      wait_idle("row", 300);
      check("row_count", instr_count, exp_cnt);
      check("row_err", err_instr, exp_err);
    end
    for (int i = 0; i < 6; i++) push_cmd(vecs[i]);
    wr_tokens(6);
    wait_idle("batch", 1000);
    check("batch_count", instr_count, exp_cnt);
    check("batch_err", err_instr, exp_err);

    // enable dropped mid-command: the in-flight one completes, the next waits
    push_cmd(vecs[0]);
    push_cmd(vecs[4]);
    wr_tokens(2);
    n = 0;
    do begin @(negedge clk); n++; end while (!start_get_cmd && n < 20);
    check("fetch_seen", start_get_cmd, 1);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check("parked_count", instr_count, exp_cnt - 1);
    check("parked_pending", pending, 1);
    check("parked_busy", busy, 0);
    enable = 1'b1;
    wait_idle("unpark", 300);
    check("unpark_count", instr_count, exp_cnt);

    // 5. cmd_wr in the FETCH cycle leaves pending unchanged
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(vecs[i]);
    wr_tokens(2);
    check("pre_fetch_pending", pending, 2);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    check("in_fetch", start_get_cmd, 1);
    cmd_wr = 1'b1;
    @(posedge clk); #1 cmd_wr = 1'b0;
    check("fetch_wr_pending", pending, 2);
    wait_idle("fetch_wr", 1000);
    check("fetch_wr_count", instr_count, exp_cnt);

    // saturation at buffer_size
    enable = 1'b0;
    wr_tokens(1025);
    check("sat_pending", pending, 1024);

    // 6. reset during WAIT_EXEC, then a late done_stp
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; exp_err = 0;
    check("post_rst_pending", pending, 0);
    auto_exec = 1'b0;
    push_cmd('{8'h00, 3'd5, 5'd9, 0, 0, 0});
    enable = 1'b1;
    wr_tokens(1);
    n = 0;
    do begin @(negedge clk); n++; end while (exp_q.size() != 0 && n < 50);
    check("stp_dispatched", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("in_wait_exec", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_args", {exec_arg1, exec_arg2}, 0);
    check("rst_mid_err_count", {err_instr, instr_count}, 0);
    @(negedge clk); rst = 1'b0;
    done_man[0] = 1'b1;
    @(negedge clk); done_man = 4'd0;
    repeat (10) @(negedge clk);
    check("late_done_count", instr_count, 0);
    check("late_done_busy", busy, 0);
    check("late_done_pending", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #800000;
    $display("FAIL watchdog actual=%0d required=0", cyc);
    $fatal(1, "watchdog");
  end

endmodule
